// File: rtl/ps2_pkg.sv
// ps2_pkg: shared codes and FSM state type for the PS/2 scan receiver
package ps2_pkg;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/ps2_input_sync.sv
// ps2_input_sync: synchronizes the PS/2 pins, glitch-filters the clock and flags its falling edges
module ps2_input_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall_tick,
  output logic o_data
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] r_clk_s, r_dat_s;
  logic [CW-1:0] r_cnt;
  logic r_filt, r_filt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_cnt <= '0;
      r_filt <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_data};
      r_filt_d <= r_filt;
      // a new level must persist FILTER_LEN samples before it is believed
      if (r_clk_s[1] == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s[1];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_fall_tick = r_filt_d & ~r_filt;
  assign o_data = r_dat_s[1];
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: decodes PS/2 set-2 frames and tracks the currently held make code
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic w_tick, w_data, w_good;
  state_t r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic r_start, r_par, r_brk, r_ext;
  logic [TW-1:0] r_to;
  ps2_input_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_ps2_clk(ps2_clk),
    .i_ps2_data(ps2_data),
    .o_fall_tick(w_tick),
    .o_data(w_data)
  );
  assign w_good = (^{r_shift, r_par}) & w_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit <= '0;
      r_start <= 1'b0;
      r_par <= 1'b0;
      r_brk <= 1'b0;
      r_ext <= 1'b0;
      r_to <= '0;
      key <= '0;
      scan_code <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      r_to <= (r_state == IDLE || w_tick) ? '0 : r_to + 1'b1;
      if (r_state != IDLE && r_to == TW'(TIMEOUT_CYCLES)) begin
        r_state <= IDLE;
        frame_err <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (w_tick) begin
            r_start <= w_data;
            r_state <= START_CHK;
          end
          START_CHK: begin
            r_bit <= '0;
            r_state <= r_start ? IDLE : DATA;
          end
          DATA: if (w_tick) begin
            r_shift <= {w_data, r_shift[7:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= PARITY;
          end
          PARITY: if (w_tick) begin
            r_par <= w_data;
            r_state <= STOP;
          end
          STOP: if (w_tick) begin
            r_state <= IDLE;
            key_valid <= w_good;
            frame_err <= ~w_good;
            if (w_good) begin
              scan_code <= r_shift;
              // prefixes arm flags; the next plain code consumes them
              if (r_shift == BREAK_CODE) r_brk <= 1'b1;
              else if (r_shift == EXT_CODE) r_ext <= 1'b1;
              else if (r_ext) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
              end else if (r_brk) begin
                r_brk <= 1'b0;
                if (r_shift == key) key <= '0;
              end else key <= r_shift;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: drives PS/2 frames and checks decode and key tracking against a reference model
module tb_ps2_scan_receiver;
  localparam int FL = 4;
  localparam int TO = 2000;
  localparam int H = 12;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
  logic [7:0] key, scan_code;
  logic key_valid, frame_err;
  int checks = 0, errors = 0;
  int n_valid = 0, n_err = 0, n_both = 0, e_valid = 0, e_err = 0;
  logic [7:0] m_key = 0, m_scan = 0;
  bit m_brk = 0, m_ext = 0;

  ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .scan_code(scan_code), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (frame_err) n_err++;
    if (key_valid && frame_err) n_both++;
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(bit b);
    ps2_data = b;
    wait_cyc(H);
    ps2_clk = 0;
    wait_cyc(H);
    ps2_clk = 1;
  endtask

  task automatic model(logic [7:0] d, bit good);
    if (!good) begin
      e_err++;
      return;
    end
    e_valid++;
    m_scan = d;
    if (d == 8'hF0) m_brk = 1;
    else if (d == 8'hE0) m_ext = 1;
    else if (m_ext) begin m_ext = 0; m_brk = 0; end
    else if (m_brk) begin m_brk = 0; if (d == m_key) m_key = 0; end
    else m_key = d;
  endtask

  task automatic send(logic [7:0] d, bit bad_par = 0, bit bad_stop = 0);
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1;
    wait_cyc(20);
    model(d, !bad_par && !bad_stop);
  endtask

  task automatic test_reset;
    rst = 1;
    wait_cyc(3);
    rst = 0;
    @(negedge clk);
    checks++; if (key !== 8'h00) begin errors++; $display("FAIL reset_key got %h exp 00", key); end
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan got %h exp 00", scan_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
  endtask

  task automatic test_good_frame;
    send(8'h16);
    @(negedge clk);
    checks++; if (n_valid !== e_valid) begin errors++; $display("FAIL good_valid got %0d exp %0d", n_valid, e_valid); end
    checks++; if (n_err !== e_err) begin errors++; $display("FAIL good_err got %0d exp %0d", n_err, e_err); end
    checks++; if (scan_code !== 8'h16) begin errors++; $display("FAIL good_scan got %h exp 16", scan_code); end
    checks++; if (key !== 8'h16) begin errors++; $display("FAIL good_key got %h exp 16", key); end
  endtask

  task automatic test_make_break;
    send(8'hF0);
    @(negedge clk);
    checks++; if (key !== 8'h16) begin errors++; $display("FAIL mb_after_f0 got %h exp 16", key); end
    send(8'h16);
    @(negedge clk);
    checks++; if (key !== 8'h00) begin errors++; $display("FAIL mb_release got %h exp 00", key); end
    send(8'h16);
    send(8'hF0);
    send(8'h1E);
    @(negedge clk);
    checks++; if (key !== 8'h16) begin errors++; $display("FAIL mb_other_release got %h exp 16", key); end
    checks++; if (key !== m_key) begin errors++; $display("FAIL mb_model got %h exp %h", key, m_key); end
  endtask

  task automatic test_parity;
    send(8'h1E, 1);
    @(negedge clk);
    checks++; if (n_err !== e_err) begin errors++; $display("FAIL par_err got %0d exp %0d", n_err, e_err); end
    checks++; if (n_valid !== e_valid) begin errors++; $display("FAIL par_valid got %0d exp %0d", n_valid, e_valid); end
    checks++; if (key !== 8'h16) begin errors++; $display("FAIL par_key got %h exp 16", key); end
    checks++; if (scan_code !== 8'h1E) begin errors++; $display("FAIL par_scan got %h exp 1E", scan_code); end
  endtask

  task automatic test_timeout;
    send_bit(0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    ps2_data = 1;
    wait_cyc(TO + 10 + 20);
    e_err++;
    @(negedge clk);
    checks++; if (n_err !== e_err) begin errors++; $display("FAIL to_err got %0d exp %0d", n_err, e_err); end
    checks++; if (n_valid !== e_valid) begin errors++; $display("FAIL to_valid got %0d exp %0d", n_valid, e_valid); end
    send(8'h26);
    @(negedge clk);
    checks++; if (key !== 8'h26) begin errors++; $display("FAIL to_next_key got %h exp 26", key); end
  endtask

  task automatic test_extended;
    int v0, e0;
    send(8'h3D);
    v0 = n_valid;
    e0 = n_err;
    send(8'hE0);
    send(8'h75);
    @(negedge clk);
    checks++; if (key !== 8'h3D) begin errors++; $display("FAIL ext_make got %h exp 3D", key); end
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    @(negedge clk);
    checks++; if (key !== 8'h3D) begin errors++; $display("FAIL ext_break got %h exp 3D", key); end
    checks++; if (n_valid - v0 !== 5) begin errors++; $display("FAIL ext_valid got %0d exp 5", n_valid - v0); end
    checks++; if (n_err !== e0) begin errors++; $display("FAIL ext_err got %0d exp %0d", n_err, e0); end
  endtask

  task automatic test_glitch;
    logic [7:0] d = 8'h25;
    send_bit(0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 3) begin
        wait_cyc(5);
        ps2_clk = 0;
        wait_cyc(2);
        ps2_clk = 1;
        wait_cyc(5);
      end
    end
    send_bit(~^d);
    send_bit(1);
    wait_cyc(20);
    model(d, 1);
    @(negedge clk);
    checks++; if (key !== 8'h25) begin errors++; $display("FAIL glitch_key got %h exp 25", key); end
    checks++; if (scan_code !== 8'h25) begin errors++; $display("FAIL glitch_scan got %h exp 25", scan_code); end
    checks++; if (n_err !== e_err) begin errors++; $display("FAIL glitch_err got %0d exp %0d", n_err, e_err); end
  endtask

  task automatic test_rst_mid;
    int e0;
    send_bit(0);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    e0 = n_err;
    rst = 1;
    wait_cyc(3);
    rst = 0;
    m_key = 0; m_scan = 0; m_brk = 0; m_ext = 0;
    ps2_data = 1;
    wait_cyc(10);
    @(negedge clk);
    checks++; if (key !== 8'h00) begin errors++; $display("FAIL rst_key got %h exp 00", key); end
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL rst_scan got %h exp 00", scan_code); end
    checks++; if (n_err !== e0) begin errors++; $display("FAIL rst_err got %0d exp %0d", n_err, e0); end
    send(8'h2E);
    @(negedge clk);
    checks++; if (key !== 8'h2E) begin errors++; $display("FAIL rst_next_key got %h exp 2E", key); end
  endtask

  task automatic test_random;
    logic [7:0] pool [6] = '{8'hF0, 8'hE0, 8'h16, 8'h1E, 8'h26, 8'h3D};
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      int r;
      r = $urandom_range(0, 7);
      d = (r < 6) ? pool[r] : 8'($urandom);
      send(d, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      @(negedge clk);
      checks++; if (key !== m_key) begin errors++; $display("FAIL rnd_key[%0d] got %h exp %h", n, key, m_key); end
      checks++; if (scan_code !== m_scan) begin errors++; $display("FAIL rnd_scan[%0d] got %h exp %h", n, scan_code, m_scan); end
      checks++; if (n_valid !== e_valid || n_err !== e_err) begin
        errors++; $display("FAIL rnd_counts[%0d] got v%0d e%0d exp v%0d e%0d", n, n_valid, n_err, e_valid, e_err);
      end
    end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL both_pulses got %0d exp 0", n_both); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_make_break;
    test_parity;
    test_timeout;
    test_extended;
    test_glitch;
    test_rst_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Receives PS/2 keyboard frames (scan code set 2) on the raw `ps2_clk`/`ps2_data` pins and produces the 8-bit held-key code consumed by the note-lookup stage. The block tracks make/break sequences, so `key` holds a make code while that key is down and returns to 0x00 on its release. It sits between the keyboard connector and the key-to-note mapping logic.

## Interface
- `FILTER_LEN`, default 4: number of consecutive clk samples the synchronized ps2_clk must hold a new level before the filtered clock changes.
- `TIMEOUT_CYCLES`, default 50000: idle clk cycles, with no filtered falling edge, after which a partial frame is aborted (1 ms at 50 MHz).
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ps2_clk`, input, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, input, 1: raw PS/2 data pin, asynchronous.
- `key`, output, 8: make code of the currently held key; 0x00 when no key is held.
- `scan_code`, output, 8: last correctly received byte; updates when `key_valid` is high.
- `key_valid`, output, 1: one-cycle pulse per correctly received frame.
- `frame_err`, output, 1: one-cycle pulse per discarded frame (parity, stop, or timeout).

## Operation
- Input path: both pins pass through 2-flop synchronizers. The synchronized clock then passes through a FILTER_LEN glitch filter. `fall_tick` pulses for one cycle when the filtered clock goes 1→0.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). Each bit is sampled from the synchronized data on `fall_tick`.
- FSM states:
  - IDLE → START_CHK on `fall_tick`.
  - If the sampled start bit is 1, the FSM stays in IDLE and the bit is ignored with no error.
  - DATA: bit counter runs 0..7, then PARITY, then STOP.
  - STOP → IDLE always.
- Frame acceptance: the frame is good if data XOR parity has odd weight and the stop bit is 1.
  - Good frame: `scan_code` ← byte and `key_valid` pulses.
  - Otherwise: `frame_err` pulses and the byte is discarded.
- Timeout: in any state other than IDLE, a counter reloads on each `fall_tick`. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, `frame_err` pulses, and the partial byte is dropped.
- Make/break tracking, applied only to good frames:
  - 0xF0: sets `brk_pend`; `key` unchanged.
  - 0xE0: sets `ext_pend`; `key` unchanged.
  - Other code with `ext_pend` set: clears both flags; `key` unchanged. Extended keys are ignored.
  - Other code with `brk_pend` set: if code == `key`, then `key` ← 0x00; otherwise `key` unchanged. Clears `brk_pend`.
  - Other code with no flag set: `key` ← code. A typematic repeat of the held code leaves `key` unchanged.
- Flags `brk_pend` and `ext_pend` survive `frame_err`. They clear only when a non-prefix code consumes them, or on `rst`.

## Timing
- Reset values: `key`=0x00, `scan_code`=0x00, `key_valid`=0, `frame_err`=0, FSM=IDLE, flags and counters cleared.
- `rst` mid-frame aborts the frame immediately, with no `frame_err` pulse.
- `fall_tick` asserts 2+FILTER_LEN+1 clk cycles after a clean raw pin fall. It is never asserted for raw clock pulses shorter than FILTER_LEN cycles.
- Stop-bit `fall_tick` in cycle N:
  - `key_valid` or `frame_err` is high in cycle N+1.
  - `scan_code` and `key` hold their new values from cycle N+1.
- Timeout pulse: `frame_err` rises one cycle after the counter hits TIMEOUT_CYCLES.
- `key_valid` and `frame_err` are never high in the same cycle.

## Structure
- Package `ps2_pkg` holds:
  - `BREAK_CODE` = 8'hF0 and `EXT_CODE` = 8'hE0.
  - The FSM state typedef (IDLE, START_CHK, DATA, PARITY, STOP).
- Sub-module `ps2_input_sync` contains the 2-flop synchronizers for both pins, the FILTER_LEN clock filter, and the `fall_tick` generation. The top level holds the FSM, shift register, timeout counter and make/break logic.

## Test plan
- Good frame: frame 0x16, parity 0 → one `key_valid` pulse; `scan_code`=0x16, `key`=0x16, no `frame_err`.
- Make/break: make 0x16, then frames F0, 16 → `key` stays 0x16 after F0 and becomes 0x00 after 16. Make 0x16, then F0, 1E → `key` stays 0x16.
- Parity error: 0x1E sent with parity 0 → `frame_err` pulse, no `key_valid`, `key` and `scan_code` unchanged.
- Timeout: start bit plus 3 data bits, then clock idle for TIMEOUT_CYCLES+10 → one `frame_err` pulse. A following full frame 0x26 gives `key`=0x26.
- Extended keys: E0, 75 then E0, F0, 75, with `key`=0x3D held → `key` remains 0x3D throughout; three or more `key_valid` pulses and no `frame_err`.
- Glitch and reset:
  - A 2-cycle low glitch on `ps2_clk` (FILTER_LEN=4) mid-frame → no bit consumed; frame 0x25 still decodes correctly.
  - `rst` asserted after 5 bits → outputs reset. The next full frame 0x2E decodes normally.
